// File: rtl/axi4_tgen_pkg.sv
// Shared types and constants for the AXI4 DDR traffic generator.
// Holds the FSM state enum, the fixed AXI field values, the LFSR polynomial/seed
// and the default address-derived data pattern.
package axi4_tgen_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } tgen_state_t;

    localparam logic [1:0]  BURST_INCR    = 2'b01;
    localparam logic [2:0]  SIZE_8B       = 3'd3;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [3:0]  CACHE_DEFAULT = 4'b0011;

    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1.
    localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;
    localparam logic [63:0] LFSR_SEED = 64'h0123_4567_89AB_CDEF;

    // Upper word is the lower word scrambled so stuck/swapped lanes show up.
    function automatic logic [63:0] addr_pattern(input logic [29:0] addr);
        logic [31:0] a32;
        a32 = {2'b00, addr};
        return {a32 ^ 32'hA5A5_A5A5, a32};
    endfunction

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/tgen_pattern.sv
// Beat data generator: address pattern by default, LFSR output/step with TGEN_LFSR_PATTERN_EN.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller owns all state and advances it on handshakes.
// Ports (default):  i_addr beat byte address -> o_data beat data.
// Ports (TGEN_LFSR_PATTERN_EN): i_lfsr current state -> o_data beat data, o_lfsr_next advanced state.
module tgen_pattern
    import axi4_tgen_pkg::*;
(
`ifdef TGEN_LFSR_PATTERN_EN
    input  logic [63:0] i_lfsr,
    output logic [63:0] o_lfsr_next,
`else
    input  logic [29:0] i_addr,
`endif
    output logic [63:0] o_data
);

`ifdef TGEN_LFSR_PATTERN_EN
    assign o_data      = i_lfsr;
    assign o_lfsr_next = lfsr_step(i_lfsr);
`else
    assign o_data = addr_pattern(i_addr);
`endif

endmodule

// File: rtl/axi4_ddr_traffic_gen.sv
// AXI4 DDR traffic generator: writes NUM_BURSTS bursts of BURST_LEN beats, reads each back and checks it.
// Latency: one channel phase per FSM state; every handshake takes effect on the next clk_clk edge.
// Backpressure: valids are registered and held with stable payload until the slave's ready.
// Ports: clk_clk/reset_reset (sync, active high), start pulse, busy/done/pass status,
//        err_count (saturating) and first_err_addr, AXI4 master aw/w/b/ar/r channels.
// Option: define TGEN_LFSR_PATTERN_EN for LFSR beat data instead of the address pattern.
module axi4_ddr_traffic_gen
    import axi4_tgen_pkg::*;
#(
    parameter int          BURST_LEN  = 16,
    parameter int          NUM_BURSTS = 64,
    parameter logic [29:0] BASE_ADDR  = 30'h0
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [29:0] first_err_addr,
    output logic [3:0]  axi_master_m0_awid,
    output logic [29:0] axi_master_m0_awaddr,
    output logic [7:0]  axi_master_m0_awlen,
    output logic [2:0]  axi_master_m0_awsize,
    output logic [1:0]  axi_master_m0_awburst,
    output logic [0:0]  axi_master_m0_awlock,
    output logic [3:0]  axi_master_m0_awcache,
    output logic [2:0]  axi_master_m0_awprot,
    output logic [3:0]  axi_master_m0_awqos,
    output logic        axi_master_m0_awvalid,
    input  logic        axi_master_m0_awready,
    output logic [63:0] axi_master_m0_wdata,
    output logic [7:0]  axi_master_m0_wstrb,
    output logic        axi_master_m0_wlast,
    output logic        axi_master_m0_wvalid,
    input  logic        axi_master_m0_wready,
    input  logic [3:0]  axi_master_m0_bid,
    input  logic [1:0]  axi_master_m0_bresp,
    input  logic        axi_master_m0_bvalid,
    output logic        axi_master_m0_bready,
    output logic [3:0]  axi_master_m0_arid,
    output logic [29:0] axi_master_m0_araddr,
    output logic [7:0]  axi_master_m0_arlen,
    output logic [2:0]  axi_master_m0_arsize,
    output logic [1:0]  axi_master_m0_arburst,
    output logic [0:0]  axi_master_m0_arlock,
    output logic [3:0]  axi_master_m0_arcache,
    output logic [2:0]  axi_master_m0_arprot,
    output logic [3:0]  axi_master_m0_arqos,
    output logic        axi_master_m0_arvalid,
    input  logic        axi_master_m0_arready,
    input  logic [3:0]  axi_master_m0_rid,
    input  logic [63:0] axi_master_m0_rdata,
    input  logic [1:0]  axi_master_m0_rresp,
    input  logic        axi_master_m0_rlast,
    input  logic        axi_master_m0_rvalid,
    output logic        axi_master_m0_rready
);

    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);
    localparam logic [29:0] BURST_BYTES = 30'(BURST_LEN * 8);

    tgen_state_t r_state;
    logic        r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready, r_done;
    logic [29:0] r_addr;
    logic [7:0]  r_beat_cnt;
    logic [15:0] r_burst_cnt;
    logic [15:0] r_err_count;
    logic [29:0] r_first_err_addr;

    logic        w_run_start, w_aw_fire, w_w_fire, w_b_fire, w_ar_fire, w_r_fire;
    logic        w_last_beat, w_b_err, w_r_err, w_err_evt;
    logic [29:0] w_beat_addr, w_err_addr;
    logic [63:0] w_wr_data, w_rd_exp;

    assign w_run_start = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_aw_fire   = r_awvalid && axi_master_m0_awready;
    assign w_w_fire    = r_wvalid  && axi_master_m0_wready;
    assign w_b_fire    = r_bready  && axi_master_m0_bvalid;
    assign w_ar_fire   = r_arvalid && axi_master_m0_arready;
    assign w_r_fire    = r_rready  && axi_master_m0_rvalid;

    // Same beat counter serves the write and the read-back of a burst.
    assign w_beat_addr = r_addr + 30'({r_beat_cnt, 3'b000});
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);

    assign w_b_err = w_b_fire && ((axi_master_m0_bresp != RESP_OKAY) || (axi_master_m0_bid != 4'd0));
    assign w_r_err = w_r_fire && ((axi_master_m0_rresp != RESP_OKAY) || (axi_master_m0_rid != 4'd0) ||
                                  (axi_master_m0_rdata != w_rd_exp) ||
                                  (axi_master_m0_rlast != w_last_beat));
    assign w_err_evt  = w_b_err || w_r_err;
    // A bad write response is attributed to the burst's first beat.
    assign w_err_addr = w_b_err ? r_addr : w_beat_addr;

`ifdef TGEN_LFSR_PATTERN_EN
    logic [63:0] r_lfsr_wr, r_lfsr_rd, w_lfsr_wr_next, w_lfsr_rd_next;

    // Both LFSRs step BURST_LEN times per burst, so the read copy stays in
    // lockstep with the writer at every burst boundary.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || w_run_start) begin
            r_lfsr_wr <= LFSR_SEED;
            r_lfsr_rd <= LFSR_SEED;
        end else begin
            if (w_w_fire) r_lfsr_wr <= w_lfsr_wr_next;
            if (w_r_fire) r_lfsr_rd <= w_lfsr_rd_next;
        end
    end

    tgen_pattern u_wr_pattern (.i_lfsr(r_lfsr_wr), .o_lfsr_next(w_lfsr_wr_next), .o_data(w_wr_data));
    tgen_pattern u_rd_pattern (.i_lfsr(r_lfsr_rd), .o_lfsr_next(w_lfsr_rd_next), .o_data(w_rd_exp));
`else
    tgen_pattern u_wr_pattern (.i_addr(w_beat_addr), .o_data(w_wr_data));
    tgen_pattern u_rd_pattern (.i_addr(w_beat_addr), .o_data(w_rd_exp));
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state          <= IDLE;
            r_awvalid        <= 1'b0;
            r_wvalid         <= 1'b0;
            r_wlast          <= 1'b0;
            r_bready         <= 1'b0;
            r_arvalid        <= 1'b0;
            r_rready         <= 1'b0;
            r_done           <= 1'b0;
            r_addr           <= 30'd0;
            r_beat_cnt       <= 8'd0;
            r_burst_cnt      <= 16'd0;
            r_err_count      <= 16'd0;
            r_first_err_addr <= 30'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state          <= WR_ADDR;
                        r_awvalid        <= 1'b1;
                        r_done           <= 1'b0;
                        r_addr           <= BASE_ADDR;
                        r_beat_cnt       <= 8'd0;
                        r_burst_cnt      <= 16'd0;
                        r_err_count      <= 16'd0;
                        r_first_err_addr <= 30'd0;
                    end
                end
                WR_ADDR: begin
                    if (w_aw_fire) begin
                        r_state    <= WR_DATA;
                        r_awvalid  <= 1'b0;
                        r_wvalid   <= 1'b1;
                        r_beat_cnt <= 8'd0;
                        r_wlast    <= (LAST_BEAT == 8'd0);
                    end
                end
                WR_DATA: begin
                    if (w_w_fire) begin
                        if (w_last_beat) begin
                            r_state    <= WR_RESP;
                            r_wvalid   <= 1'b0;
                            r_wlast    <= 1'b0;
                            r_bready   <= 1'b1;
                            r_beat_cnt <= 8'd0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                            r_wlast    <= ((r_beat_cnt + 8'd1) == LAST_BEAT);
                        end
                    end
                end
                WR_RESP: begin
                    if (w_b_fire) begin
                        r_state   <= RD_ADDR;
                        r_bready  <= 1'b0;
                        r_arvalid <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (w_ar_fire) begin
                        r_state    <= RD_DATA;
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_beat_cnt <= 8'd0;
                    end
                end
                RD_DATA: begin
                    if (w_r_fire) begin
                        // The slave's rlast ends the burst even if it arrives on the wrong beat.
                        if (axi_master_m0_rlast) begin
                            r_rready   <= 1'b0;
                            r_beat_cnt <= 8'd0;
                            if (r_burst_cnt == LAST_BURST) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= WR_ADDR;
                                r_awvalid   <= 1'b1;
                                r_burst_cnt <= r_burst_cnt + 16'd1;
                                r_addr      <= r_addr + BURST_BYTES;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Errors only occur in WR_RESP/RD_DATA, never alongside the start-clear.
            if (w_err_evt) begin
                if (r_err_count == 16'd0) r_first_err_addr <= w_err_addr;
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign busy           = (r_state != IDLE) && (r_state != DONE);
    assign done           = r_done;
    assign pass           = r_done && (r_err_count == 16'd0);
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;

    assign axi_master_m0_awid    = 4'd0;
    assign axi_master_m0_awaddr  = r_addr;
    assign axi_master_m0_awlen   = LAST_BEAT;
    assign axi_master_m0_awsize  = SIZE_8B;
    assign axi_master_m0_awburst = BURST_INCR;
    assign axi_master_m0_awlock  = 1'b0;
    assign axi_master_m0_awcache = CACHE_DEFAULT;
    assign axi_master_m0_awprot  = 3'd0;
    assign axi_master_m0_awqos   = 4'd0;
    assign axi_master_m0_awvalid = r_awvalid;

    assign axi_master_m0_wdata   = w_wr_data;
    assign axi_master_m0_wstrb   = 8'hFF;
    assign axi_master_m0_wlast   = r_wlast;
    assign axi_master_m0_wvalid  = r_wvalid;
    assign axi_master_m0_bready  = r_bready;

    assign axi_master_m0_arid    = 4'd0;
    assign axi_master_m0_araddr  = r_addr;
    assign axi_master_m0_arlen   = LAST_BEAT;
    assign axi_master_m0_arsize  = SIZE_8B;
    assign axi_master_m0_arburst = BURST_INCR;
    assign axi_master_m0_arlock  = 1'b0;
    assign axi_master_m0_arcache = CACHE_DEFAULT;
    assign axi_master_m0_arprot  = 3'd0;
    assign axi_master_m0_arqos   = 4'd0;
    assign axi_master_m0_arvalid = r_arvalid;
    assign axi_master_m0_rready  = r_rready;

endmodule

// File: tb/tb_axi4_ddr_traffic_gen.sv
// Testbench for axi4_ddr_traffic_gen with a small AXI4 memory slave model.
// Latency: slave answers each request on the following cycle unless stalling.
// Backpressure: slave can hold awready/wready low for 0..5 cycles in stall mode.
module tb_axi4_ddr_traffic_gen;

    localparam int BL = 16;
    localparam int NB = 2;
    localparam int M_IDEAL = 0, M_STALL = 1, M_CORRUPT = 2, M_BRESP = 3;

    logic clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    logic        reset_reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [29:0] first_err_addr;
    logic [3:0]  awid, arid;
    logic [29:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst;
    logic [0:0]  awlock, arlock;
    logic [3:0]  awcache, arcache, awqos, arqos;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0;
    logic [3:0]  bid = 4'd0, rid = 4'd0;
    logic [1:0]  bresp = 2'd0, rresp = 2'd0;
    logic [63:0] rdata = 64'd0;

    axi4_ddr_traffic_gen #(.BURST_LEN(BL), .NUM_BURSTS(NB), .BASE_ADDR(30'h0)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .axi_master_m0_awid(awid), .axi_master_m0_awaddr(awaddr), .axi_master_m0_awlen(awlen),
        .axi_master_m0_awsize(awsize), .axi_master_m0_awburst(awburst), .axi_master_m0_awlock(awlock),
        .axi_master_m0_awcache(awcache), .axi_master_m0_awprot(awprot), .axi_master_m0_awqos(awqos),
        .axi_master_m0_awvalid(awvalid), .axi_master_m0_awready(awready),
        .axi_master_m0_wdata(wdata), .axi_master_m0_wstrb(wstrb), .axi_master_m0_wlast(wlast),
        .axi_master_m0_wvalid(wvalid), .axi_master_m0_wready(wready),
        .axi_master_m0_bid(bid), .axi_master_m0_bresp(bresp), .axi_master_m0_bvalid(bvalid),
        .axi_master_m0_bready(bready),
        .axi_master_m0_arid(arid), .axi_master_m0_araddr(araddr), .axi_master_m0_arlen(arlen),
        .axi_master_m0_arsize(arsize), .axi_master_m0_arburst(arburst), .axi_master_m0_arlock(arlock),
        .axi_master_m0_arcache(arcache), .axi_master_m0_arprot(arprot), .axi_master_m0_arqos(arqos),
        .axi_master_m0_arvalid(arvalid), .axi_master_m0_arready(arready),
        .axi_master_m0_rid(rid), .axi_master_m0_rdata(rdata), .axi_master_m0_rresp(rresp),
        .axi_master_m0_rlast(rlast), .axi_master_m0_rvalid(rvalid), .axi_master_m0_rready(rready)
    );

    function automatic logic [63:0] pat(input logic [29:0] a);
        logic [31:0] z;
        z = {2'b00, a};
        return {z ^ 32'hA5A5_A5A5, z};
    endfunction

    // ---------------- slave model (acts on negedge, so its decisions hold at the next posedge)
    int          mode = M_IDEAL;
    logic [63:0] mem [16];
    logic [29:0] aw_log [16];
    logic [29:0] cur_addr = 30'd0;
    int aw_cnt = 0, w_total = 0, r_total = 0, sl_wbeat = 0;
    int wdata_bad = 0, field_bad = 0, stab_bad = 0, stab_events = 0;
    int aw_stall = 0, w_stall = 0, r_beat = 0;
    bit b_pend = 0, b_fired = 0, r_active = 0, r_fired = 0;
    bit aw_hold = 0, w_hold = 0, hold_wlast = 0;
    logic [29:0] hold_awaddr = 30'd0;
    logic [63:0] hold_wdata = 64'd0;

    always @(negedge clk_clk) begin
        if (reset_reset) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
            bresp = 0; rdata = 0;
            aw_cnt = 0; w_total = 0; r_total = 0; sl_wbeat = 0;
            wdata_bad = 0; field_bad = 0; stab_bad = 0; stab_events = 0;
            aw_stall = (mode == M_STALL) ? 2 : 0;
            w_stall  = (mode == M_STALL) ? 2 : 0;
            b_pend = 0; b_fired = 0; r_active = 0; r_fired = 0; r_beat = 0;
            aw_hold = 0; w_hold = 0;
        end else begin
            // payload must not move while valid waits for ready
            if (aw_hold) begin
                stab_events++;
                if (!awvalid || awaddr !== hold_awaddr) stab_bad++;
            end
            if (w_hold) begin
                stab_events++;
                if (!wvalid || wdata !== hold_wdata || wlast !== hold_wlast) stab_bad++;
            end

            // B (before W so the response follows the wlast handshake by a cycle)
            if (b_fired) begin bvalid = 0; b_fired = 0; end
            if (b_pend && !bvalid) begin
                bvalid = 1; b_pend = 0;
                bresp = (mode == M_BRESP && aw_cnt == 1) ? 2'b10 : 2'b00;
            end
            if (bvalid && bready) b_fired = 1;

            // R (before AR for the same reason)
            if (r_fired) begin
                r_fired = 0; r_beat++;
                if (r_beat == BL) r_active = 0;
            end
            rvalid = r_active;
            rlast  = r_active && (r_beat == BL - 1);
            rdata  = r_active ? mem[r_beat[3:0]] : 64'd0;
            if (r_active && mode == M_CORRUPT && aw_cnt == 2 && r_beat == 3) rdata[0] = ~rdata[0];
            if (rvalid && rready) begin r_fired = 1; r_total++; end

            // AW
            if (aw_stall > 0) begin awready = 0; aw_stall--; end else awready = 1;
            if (awvalid && awready) begin
                if (awid !== 4'd0 || awlen !== 8'(BL - 1) || awsize !== 3'd3 || awburst !== 2'b01 ||
                    awlock !== 1'b0 || awcache !== 4'b0011 || awprot !== 3'd0 || awqos !== 4'd0)
                    field_bad++;
                aw_log[aw_cnt[3:0]] = awaddr;
                cur_addr = awaddr; aw_cnt++; sl_wbeat = 0;
                if (mode == M_STALL) begin
                    aw_stall = int'($urandom_range(0, 5));
                    w_stall  = int'($urandom_range(1, 5));
                end
            end
            aw_hold = awvalid && !awready; hold_awaddr = awaddr;

            // W
            if (w_stall > 0) begin wready = 0; w_stall--; end else wready = 1;
            if (wvalid && wready) begin
                if (wdata !== pat(cur_addr + 30'(sl_wbeat * 8)) || wlast !== (sl_wbeat == BL - 1) ||
                    wstrb !== 8'hFF || sl_wbeat >= BL)
                    wdata_bad++;
                if (sl_wbeat < BL) mem[sl_wbeat[3:0]] = wdata;
                sl_wbeat++; w_total++;
                if (wlast) b_pend = 1;
                if (mode == M_STALL) w_stall = int'($urandom_range(0, 5));
            end
            w_hold = wvalid && !wready; hold_wdata = wdata; hold_wlast = wlast;

            // AR
            arready = 1;
            if (arvalid && arready) begin
                if (arid !== 4'd0 || araddr !== cur_addr || arlen !== 8'(BL - 1) || arsize !== 3'd3 ||
                    arburst !== 2'b01 || arlock !== 1'b0 || arcache !== 4'b0011 || arprot !== 3'd0 ||
                    arqos !== 4'd0)
                    field_bad++;
                r_active = 1; r_beat = 0;
            end
        end
    end

    // ---------------- checking
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_reset = 1'b1;
        cyc(); cyc();
        reset_reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 3000 && !done; n++) cyc();
        check(name, 64'(done), 64'd1);
    endtask

    typedef struct {
        int          mode;
        logic [15:0] exp_err;
        logic [29:0] exp_first;
        logic        exp_pass;
        int          exp_w;
        int          exp_r;
        logic [29:0] exp_aw0;
        logic [29:0] exp_aw1;
        logic        exp_stalls;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{M_IDEAL,   16'd0, 30'h00, 1'b1, 32, 32, 30'h0, 30'h80, 1'b0};
        vecs[1] = '{M_STALL,   16'd0, 30'h00, 1'b1, 32, 32, 30'h0, 30'h80, 1'b1};
        vecs[2] = '{M_CORRUPT, 16'd1, 30'h98, 1'b0, 32, 32, 30'h0, 30'h80, 1'b0};
        vecs[3] = '{M_BRESP,   16'd1, 30'h00, 1'b0, 32, 32, 30'h0, 30'h80, 1'b0};

        // reset state
        cyc(); cyc();
        check("rst_ctrl", 64'({busy, done, pass, awvalid, wvalid, wlast, bready, arvalid, rready}), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_first_err", 64'(first_err_addr), 64'd0);
        check("rst_addr", 64'({awaddr, araddr}), 64'd0);

        // table-driven full runs
        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            apply_reset();
            pulse_start();
            wait_done($sformatf("v%0d_done", i));
            check($sformatf("v%0d_pass", i), 64'(pass), 64'(vecs[i].exp_pass));
            check($sformatf("v%0d_err_count", i), 64'(err_count), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_first_err", i), 64'(first_err_addr), 64'(vecs[i].exp_first));
            check($sformatf("v%0d_w_beats", i), 64'(w_total), 64'(vecs[i].exp_w));
            check($sformatf("v%0d_r_beats", i), 64'(r_total), 64'(vecs[i].exp_r));
            check($sformatf("v%0d_aw_cnt", i), 64'(aw_cnt), 64'(NB));
            check($sformatf("v%0d_aw0", i), 64'(aw_log[0]), 64'(vecs[i].exp_aw0));
            check($sformatf("v%0d_aw1", i), 64'(aw_log[1]), 64'(vecs[i].exp_aw1));
            check($sformatf("v%0d_wdata_bad", i), 64'(wdata_bad), 64'd0);
            check($sformatf("v%0d_field_bad", i), 64'(field_bad), 64'd0);
            check($sformatf("v%0d_stab_bad", i), 64'(stab_bad), 64'd0);
            check($sformatf("v%0d_stalls_seen", i), 64'(stab_events > 0), 64'(vecs[i].exp_stalls));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
        end

        // reset during write beat 5 abandons the run
        mode = M_IDEAL;
        apply_reset();
        pulse_start();
        for (int n = 0; n < 500 && !(wvalid && sl_wbeat == 5); n++) cyc();
        check("a_reach_beat5", 64'(wvalid && sl_wbeat == 5), 64'd1);
        reset_reset = 1'b1;
        cyc();
        check("a_rst_ctrl", 64'({awvalid, wvalid, wlast, bready, arvalid, rready, busy, done}), 64'd0);
        reset_reset = 1'b0;
        cyc(); cyc(); cyc();
        check("a_no_resume", 64'({busy, awvalid, wvalid}), 64'd0);
        pulse_start();
        wait_done("a_done");
        check("a_pass", 64'(pass), 64'd1);
        check("a_w_beats", 64'(w_total), 64'd32);

        // start while busy is ignored; start after done clears and restarts at BASE_ADDR
        mode = M_CORRUPT;
        apply_reset();
        pulse_start();
        repeat (10) cyc();
        check("b_busy", 64'(busy), 64'd1);
        pulse_start();
        wait_done("b_done1");
        check("b_err1", 64'(err_count), 64'd1);
        check("b_aw_cnt1", 64'(aw_cnt), 64'd2);
        check("b_w_beats1", 64'(w_total), 64'd32);
        mode = M_IDEAL;
        pulse_start();
        check("b_restart_state", 64'({done, busy}), 64'b01);
        check("b_restart_err", 64'(err_count), 64'd0);
        check("b_restart_first", 64'(first_err_addr), 64'd0);
        wait_done("b_done2");
        check("b_pass2", 64'(pass), 64'd1);
        check("b_aw2", 64'(aw_log[2]), 64'h0);
        check("b_aw3", 64'(aw_log[3]), 64'h80);
        check("b_w_beats2", 64'(w_total), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
